booth_r8_encoder: RTL and testbench
===================================

BOOTH_R8_ENCODER -- requirements
Module: booth_r8_encoder

Interface
REQ-001 SHALL have parameter: N, 8, operand width (two's complement); derived localparam D = (N+2)/3 digits.
REQ-002 SHALL have port: clk  input  1  clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: stall  input  1  global freeze, all registers hold when 1.
REQ-005 SHALL have port: in_valid  input  1  X/Y beat valid.
REQ-006 SHALL have port: X  input  N  multiplier, to be Booth-recoded.
REQ-007 SHALL have port: Y  input  N  multiplicand.
REQ-008 SHALL have port: Y_out  output  N  registered multiplicand.
REQ-009 SHALL have port: x3_Y_out  output  N+2  registered 3*Y, sign-extended.
REQ-010 SHALL have ports: s_out, d_out, t_out, q_out, n_out  output  D each  per-digit control bits; bit i belongs to digit i.
REQ-011 SHALL have port: out_valid  output  1  digit vectors valid.

Function
REQ-012 SHALL recode digit i from window {Xe[3i+2], Xe[3i+1], Xe[3i], Xe[3i-1]}: Xe = X sign-extended to 3D bits, Xe[-1]=0; value = -4*b3 + 2*b2 + b1 + b0.
REQ-013 SHALL emit canonical code {s,d,t,q,n}: 0=11000, +1=00110, +2=00100, +3=10000, +4=01110, -4=01111, -3=10001, -2=00101, -1=00111.
REQ-014 SHALL use a three-stage pipeline: S1 registers X, Y, in_valid; S2 registers Y, x3_Y = Y + (Y<<1) at N+2 bits, and the recoded digits; S3 re-registers the digits and valid.
REQ-015 SHALL drive Y_out/x3_Y_out from S2 and digits/out_valid from S3, so Y_out/x3_Y_out lead the matching digits by exactly one cycle, matching the downstream multiplier's internal operand register.
REQ-016 SHALL have a latency of 3 cycles from in_valid to out_valid, with Y_out updated 2 cycles after capture; throughput is 1 beat/cycle.
REQ-017 SHALL treat in_valid=0 as a bubble: S1 loads X=0, Y=0, so the bubble carries all-zero digits (11000 per digit), Y_out=0, and x3_Y_out=0.
REQ-018 SHALL hold every register, including valid bits, while stall=1; in_valid during stall is ignored (not captured).
REQ-019 SHALL recode X = most-negative value correctly with no overflow (top digit uses sign-extension bits).

Reset
REQ-020 SHALL, while rst=0, clear all pipeline state regardless of clk and stall.
REQ-021 SHALL set reset output values: Y_out=0, x3_Y_out=0, out_valid=0, s_out and d_out all ones, t_out, q_out and n_out all zeros (zero digit).
REQ-022 SHALL discard in-flight beats on reset mid-stream; the first valid output after release appears 3 cycles after the first captured beat.

Configuration
REQ-023 SHALL, with macro BOOTH_ENC_ZFLAG_EN defined, add output zero_out (1 bit, S3-aligned) = out_valid AND all digits zero, reset 0, held under stall.
REQ-024 SHALL, without BOOTH_ENC_ZFLAG_EN, have no zero_out port and no associated logic.

Verification (N=8, D=3)
REQ-025 SHALL cover: reset asserted -> outputs per REQ-021; s_out=3'b111, d_out=3'b111.
REQ-026 SHALL cover: X=8'h7F, Y=8'h7F, in_valid one cycle -> cycle+2 Y_out=8'h7F, x3_Y_out=10'h17D; cycle+3 out_valid=1, s=010, d=010, t=101, q=001, n=001 (digits -1, 0, +2).
REQ-027 SHALL cover: X=8'h80, Y=8'h80 -> x3_Y_out=10'h280; digits 0, 0, -2: s=011, d=011, t=100, q=000, n=100.
REQ-028 SHALL cover: X=8'h01 back-to-back with X=8'h7F -> consecutive out_valid cycles; digit0 codes 00110 then 00111.
REQ-029 SHALL cover: stall=1 for 4 cycles mid-stream -> all outputs frozen, no beat lost or duplicated after release.
REQ-030 SHALL cover: with BOOTH_ENC_ZFLAG_EN, X=0 valid -> zero_out=1 with out_valid; X=8'h01 -> zero_out=0; a bubble gives zero_out=0.

Source files
------------

// File: rtl/booth_r8_encoder.sv
// Three-stage radix-8 Booth recoder: registers the operands, precomputes 3*Y and emits per-digit {s,d,t,q,n} controls.
// Defining BOOTH_ENC_ZFLAG_EN adds the S3-aligned zero_out flag; the default build omits it.
module booth_r8_encoder #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 in_valid,
  input  logic [N-1:0]         X,
  input  logic [N-1:0]         Y,
  output logic [N-1:0]         Y_out,
  output logic [N+1:0]         x3_Y_out,
  output logic [(N+2)/3-1:0]   s_out,
  output logic [(N+2)/3-1:0]   d_out,
  output logic [(N+2)/3-1:0]   t_out,
  output logic [(N+2)/3-1:0]   q_out,
  output logic [(N+2)/3-1:0]   n_out,
`ifdef BOOTH_ENC_ZFLAG_EN
  output logic                 zero_out,
`endif
  output logic                 out_valid
);

  localparam int D  = (N + 2) / 3;
  localparam int XW = 3 * D;

  logic [N-1:0] s1_x, s1_y;
  logic         s1_valid;
  logic [N-1:0] s2_y;
  logic [N+1:0] s2_x3y;
  logic         s2_valid;
  logic [D-1:0] s2_s, s2_d, s2_t, s2_q, s2_n;
  logic [D-1:0] s3_s, s3_d, s3_t, s3_q, s3_n;
  logic         s3_valid;

  logic [XW:0]  win;
  logic [N+1:0] x3y;
  logic [D-1:0] rc_s, rc_d, rc_t, rc_q, rc_n;

  // Window bits {b3,b2,b1,b0}; value = -4*b3 + 2*b2 + b1 + b0, returned as {s,d,t,q,n}.
  function automatic logic [4:0] recode(input logic [3:0] w);
    logic [4:0] code;
    case (w)
      4'b0001, 4'b0010: code = 5'b00110;  // +1
      4'b0011, 4'b0100: code = 5'b00100;  // +2
      4'b0101, 4'b0110: code = 5'b10000;  // +3
      4'b0111:          code = 5'b01110;  // +4
      4'b1000:          code = 5'b01111;  // -4
      4'b1001, 4'b1010: code = 5'b10001;  // -3
      4'b1011, 4'b1100: code = 5'b00101;  // -2
      4'b1101, 4'b1110: code = 5'b00111;  // -1
      default:          code = 5'b11000;  // 0
    endcase
    return code;
  endfunction

  always_comb begin
    // NOTE: every variable gets a full default before any partial update so no latch is inferred.
    win  = '0;
    rc_s = '0;
    rc_d = '0;
    rc_t = '0;
    rc_q = '0;
    rc_n = '0;
    // Bit 0 of win is the implicit Xe[-1]=0; the rest is X sign-extended to 3D bits.
    win[XW:1] = {XW{s1_x[N-1]}};
    win[N:1]  = s1_x;
    for (int i = 0; i < D; i++) begin
      {rc_s[i], rc_d[i], rc_t[i], rc_q[i], rc_n[i]} = recode(win[3*i +: 4]);
    end
  end

  assign x3y = {{2{s1_y[N-1]}}, s1_y} + {s1_y[N-1], s1_y, 1'b0};

  // Bubbles load zero operands so an idle slot carries zero digits and a zero multiplicand.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    if (!rst) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_x     <= in_valid ? X : '0;
      s1_y     <= in_valid ? Y : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_y     <= '0;
      s2_x3y   <= '0;
      s2_valid <= 1'b0;
      s2_s     <= '1;
      s2_d     <= '1;
      s2_t     <= '0;
      s2_q     <= '0;
      s2_n     <= '0;
    end else if (!stall) begin
      s2_y     <= s1_y;
      s2_x3y   <= x3y;
      s2_valid <= s1_valid;
      s2_s     <= rc_s;
      s2_d     <= rc_d;
      s2_t     <= rc_t;
      s2_q     <= rc_q;
      s2_n     <= rc_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_valid <= 1'b0;
      s3_s     <= '1;
      s3_d     <= '1;
      s3_t     <= '0;
      s3_q     <= '0;
      s3_n     <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_s     <= s2_s;
      s3_d     <= s2_d;
      s3_t     <= s2_t;
      s3_q     <= s2_q;
      s3_n     <= s2_n;
    end
  end

`ifdef BOOTH_ENC_ZFLAG_EN
  logic s3_zero;

  // Zero digit is uniquely s=1,d=1,t=q=n=0; the flag is registered alongside the S3 digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_zero <= 1'b0;
    end else if (!stall) begin
      s3_zero <= s2_valid & (&s2_s) & (&s2_d) & ~(|(s2_t | s2_q | s2_n));
    end
  end

  assign zero_out = s3_zero;
`endif

  // Operand outputs come from S2, one cycle ahead of the digits they pair with.
  assign Y_out     = s2_y;
  assign x3_Y_out  = s2_x3y;
  assign s_out     = s3_s;
  assign d_out     = s3_d;
  assign t_out     = s3_t;
  assign q_out     = s3_q;
  assign n_out     = s3_n;
  assign out_valid = s3_valid;

endmodule

// File: tb/tb_booth_r8_encoder.sv
// Directed testbench for booth_r8_encoder (N=8, D=3); inputs change and outputs are sampled on the falling edge.
// Define BOOTH_ENC_ZFLAG_EN to also exercise zero_out.
module tb_booth_r8_encoder;
  localparam int N = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst, stall, in_valid;
  logic [N-1:0] X, Y, Y_out;
  logic [N+1:0] x3_Y_out;
  logic [D-1:0] s_out, d_out, t_out, q_out, n_out;
  logic         out_valid;
`ifdef BOOTH_ENC_ZFLAG_EN
  logic         zero_out;
`endif

  int checks   = 0;
  int failures = 0;

  logic [5*D-1:0] digits;
  logic [4:0]     dig0;
  assign digits = {s_out, d_out, t_out, q_out, n_out};
  assign dig0   = {s_out[0], d_out[0], t_out[0], q_out[0], n_out[0]};

  localparam logic [14:0] DIG_ZERO = {3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
  localparam logic [14:0] DIG_01   = {3'b110, 3'b110, 3'b001, 3'b001, 3'b000};  // 0, 0, +1
  localparam logic [14:0] DIG_7F   = {3'b010, 3'b010, 3'b101, 3'b001, 3'b001};  // +2, 0, -1
  localparam logic [14:0] DIG_80   = {3'b011, 3'b011, 3'b100, 3'b000, 3'b100};  // -2, 0, 0

  booth_r8_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .in_valid (in_valid),
    .X        (X),
    .Y        (Y),
    .Y_out    (Y_out),
    .x3_Y_out (x3_Y_out),
    .s_out    (s_out),
    .d_out    (d_out),
    .t_out    (t_out),
    .q_out    (q_out),
    .n_out    (n_out),
`ifdef BOOTH_ENC_ZFLAG_EN
    .zero_out (zero_out),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
    in_valid = v;
    X        = x;
    Y        = y;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    stall = 1'b1;
    drive(1'b1, 8'h7F, 8'h7F);
    repeat (3) @(negedge clk);
    checks++; if (Y_out !== 8'h00) begin failures++; $display("FAIL reset_y_out: got %h want 00", Y_out); end
    checks++; if (x3_Y_out !== 10'h000) begin failures++; $display("FAIL reset_x3y: got %h want 000", x3_Y_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (digits !== DIG_ZERO) begin failures++; $display("FAIL reset_digits: got %b want %b", digits, DIG_ZERO); end
    stall = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max_pos();
    drive(1'b1, 8'h7F, 8'h7F);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (Y_out !== 8'h7F) begin failures++; $display("FAIL maxpos_y_out: got %h want 7f", Y_out); end
    checks++; if (x3_Y_out !== 10'h17D) begin failures++; $display("FAIL maxpos_x3y: got %h want 17d", x3_Y_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL maxpos_early_valid: got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL maxpos_out_valid: got %b want 1", out_valid); end
    checks++; if (digits !== DIG_7F) begin failures++; $display("FAIL maxpos_digits: got %b want %b", digits, DIG_7F); end
    checks++; if (x3_Y_out !== 10'h000) begin failures++; $display("FAIL bubble_x3y: got %h want 000", x3_Y_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    checks++; if (digits !== DIG_ZERO) begin failures++; $display("FAIL bubble_digits: got %b want %b", digits, DIG_ZERO); end
  endtask

  task automatic test_most_neg();
    drive(1'b1, 8'h80, 8'h80);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (Y_out !== 8'h80) begin failures++; $display("FAIL mostneg_y_out: got %h want 80", Y_out); end
    checks++; if (x3_Y_out !== 10'h280) begin failures++; $display("FAIL mostneg_x3y: got %h want 280", x3_Y_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mostneg_out_valid: got %b want 1", out_valid); end
    checks++; if (digits !== DIG_80) begin failures++; $display("FAIL mostneg_digits: got %b want %b", digits, DIG_80); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h01, 8'h05);
    @(negedge clk);
    drive(1'b1, 8'h7F, 8'h03);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    checks++; if (x3_Y_out !== 10'h00F) begin failures++; $display("FAIL b2b_x3y_a: got %h want 00f", x3_Y_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_a: got %b want 1", out_valid); end
    checks++; if (dig0 !== 5'b00110) begin failures++; $display("FAIL b2b_dig0_a: got %b want 00110", dig0); end
    checks++; if (Y_out !== 8'h03) begin failures++; $display("FAIL b2b_y_out_b: got %h want 03", Y_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_b: got %b want 1", out_valid); end
    checks++; if (dig0 !== 5'b00111) begin failures++; $display("FAIL b2b_dig0_b: got %b want 00111", dig0); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    drive(1'b1, 8'h01, 8'h02);
    @(negedge clk);
    drive(1'b1, 8'h7F, 8'h7F);
    @(negedge clk);
    drive(1'b1, 8'h80, 8'h80);
    @(negedge clk);
    stall = 1'b1;
    drive(1'b1, 8'h55, 8'h55);
    checks++; if (digits !== DIG_01) begin failures++; $display("FAIL stall_entry_digits: got %b want %b", digits, DIG_01); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", c, out_valid); end
      checks++; if (digits !== DIG_01) begin failures++; $display("FAIL stall_hold_digits[%0d]: got %b want %b", c, digits, DIG_01); end
      checks++; if (Y_out !== 8'h7F) begin failures++; $display("FAIL stall_hold_y_out[%0d]: got %h want 7f", c, Y_out); end
      checks++; if (x3_Y_out !== 10'h17D) begin failures++; $display("FAIL stall_hold_x3y[%0d]: got %h want 17d", c, x3_Y_out); end
    end
    stall = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_rel_valid_b: got %b want 1", out_valid); end
    checks++; if (digits !== DIG_7F) begin failures++; $display("FAIL stall_rel_digits_b: got %b want %b", digits, DIG_7F); end
    checks++; if (x3_Y_out !== 10'h280) begin failures++; $display("FAIL stall_rel_x3y_c: got %h want 280", x3_Y_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_rel_valid_c: got %b want 1", out_valid); end
    checks++; if (digits !== DIG_80) begin failures++; $display("FAIL stall_rel_digits_c: got %b want %b", digits, DIG_80); end
    checks++; if (Y_out !== 8'h00) begin failures++; $display("FAIL stall_rel_y_out_bubble: got %h want 00", Y_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 8'h7F, 8'h7F);
    @(negedge clk);
    drive(1'b1, 8'h01, 8'h01);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    #1 rst = 1'b0;
    #1;
    checks++; if (Y_out !== 8'h00) begin failures++; $display("FAIL midrst_async_y_out: got %h want 00", Y_out); end
    checks++; if (digits !== DIG_ZERO) begin failures++; $display("FAIL midrst_async_digits: got %b want %b", digits, DIG_ZERO); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_discard[%0d]: got %b want 0", c, out_valid); end
    end
    drive(1'b1, 8'h80, 8'h80);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_early_valid: got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_first_valid: got %b want 1", out_valid); end
    checks++; if (digits !== DIG_80) begin failures++; $display("FAIL midrst_first_digits: got %b want %b", digits, DIG_80); end
    @(negedge clk);
  endtask

`ifdef BOOTH_ENC_ZFLAG_EN
  task automatic test_zflag();
    drive(1'b1, 8'h00, 8'h11);
    @(negedge clk);
    drive(1'b1, 8'h01, 8'h11);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if ({out_valid, zero_out} !== 2'b11) begin failures++; $display("FAIL zflag_zero: got %b want 11", {out_valid, zero_out}); end
    @(negedge clk);
    checks++; if ({out_valid, zero_out} !== 2'b10) begin failures++; $display("FAIL zflag_nonzero: got %b want 10", {out_valid, zero_out}); end
    @(negedge clk);
    checks++; if ({out_valid, zero_out} !== 2'b00) begin failures++; $display("FAIL zflag_bubble: got %b want 00", {out_valid, zero_out}); end
  endtask
`endif

  initial begin
    test_reset();
    test_max_pos();
    test_most_neg();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
`ifdef BOOTH_ENC_ZFLAG_EN
    test_zflag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
